// File: rtl/fpu_issue.sv
// Single-issue dispatcher for an FP pipeline: routes each request to one of four
// execution-unit wrappers or resolves it locally, then presents one writeback.
module fpu_issue #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [5:0]  req_rd,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [3:0]  unit_en,
  input  logic [3:0]  unit_busy,
  input  logic [3:0]  unit_done,
  input  logic [31:0] fadd_result,
  input  logic [31:0] fsub_result,
  input  logic [31:0] fmul_result,
  input  logic [31:0] fdiv_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [5:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err_illegal,
  output logic        err_timeout,
  output logic        err_spurious
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  state_t      state, state_nx;
  logic [3:0]  sel;
  logic [5:0]  rd;
  logic [7:0]  cnt;
  logic [31:0] sel_result;
  logic        sel_free;
  logic        sel_done;
  logic        timeout;

  assign sel_free = (unit_busy & sel) == 4'b0000;
  assign sel_done = (state == WAIT) && ((unit_done & sel) != 4'b0000);
  assign timeout  = (state == WAIT) && (cnt == CNT_LAST);

  // State register; the reset is synchronous to match the rest of the codebase.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: every always_comb assigns its outputs a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          case (req_op)
            3'd0, 3'd1, 3'd2, 3'd3: state_nx = ISSUE;
            3'd4, 3'd5, 3'd6:       state_nx = WB;
            default:                state_nx = IDLE;
          endcase
        end
      end
      ISSUE:   if (sel_free) state_nx = WAIT;
      WAIT:    if (sel_done || timeout) state_nx = WB;
      WB:      if (wb_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    wb_valid  = (state == WB);
    unit_en   = 4'b0000;
    if (state == ISSUE && sel_free) unit_en = sel;
  end

  // sel is one-hot, so a priority chain is equivalent to a parallel mux here.
  always_comb begin
    sel_result = 32'h0;
    if      (sel[0]) sel_result = fadd_result;
    else if (sel[1]) sel_result = fsub_result;
    else if (sel[2]) sel_result = fmul_result;
    else if (sel[3]) sel_result = fdiv_result;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      op_a         <= 32'h0;
      op_b         <= 32'h0;
      sel          <= 4'b0000;
      rd           <= 6'd0;
      cnt          <= 8'd0;
      wb_rd        <= 6'd0;
      wb_data      <= 32'h0;
      err_illegal  <= 1'b0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      err_illegal  <= 1'b0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_a <= req_a;
            op_b <= req_b;
            rd   <= req_rd;
            sel  <= 4'b0001 << req_op[1:0];
            case (req_op)
              3'd4: begin wb_data <= req_a ^ 32'h8000_0000; wb_rd <= req_rd; end
              3'd5: begin wb_data <= req_a & 32'h7FFF_FFFF; wb_rd <= req_rd; end
              3'd6: begin wb_data <= req_a;                 wb_rd <= req_rd; end
              3'd7: err_illegal <= 1'b1;
              default: ;
            endcase
          end
        end
        ISSUE: cnt <= 8'd0;
        WAIT: begin
          cnt <= cnt + 8'd1;
          if ((unit_done & ~sel) != 4'b0000) err_spurious <= 1'b1;
          // A real completion on the last allowed cycle beats the timeout.
          if (sel_done) begin
            wb_data <= sel_result;
            wb_rd   <= rd;
          end else if (timeout) begin
            err_timeout <= 1'b1;
            wb_data     <= QNAN;
            wb_rd       <= rd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue.sv
// Directed bench for fpu_issue: unit dispatch, local ops, back-pressure,
// timeout boundary, illegal/spurious errors and mid-operation reset.
module tb_fpu_issue;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [5:0]  req_rd;
  logic [31:0] op_a, op_b;
  logic [3:0]  unit_en, unit_busy, unit_done;
  logic [31:0] fadd_result, fsub_result, fmul_result, fdiv_result;
  logic        wb_valid, wb_ready;
  logic [5:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_illegal, err_timeout, err_spurious;

  int n_cmp = 0;
  int n_err = 0;

  fpu_issue #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .op_a(op_a), .op_b(op_b),
    .unit_en(unit_en), .unit_busy(unit_busy), .unit_done(unit_done),
    .fadd_result(fadd_result), .fsub_result(fsub_result),
    .fmul_result(fmul_result), .fdiv_result(fdiv_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_illegal(err_illegal), .err_timeout(err_timeout), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [5:0] rd);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_rd    = rd;
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0; req_rd = '0;
    unit_busy = 4'b0; unit_done = 4'b0; wb_ready = 1'b1;
    fadd_result = '0; fsub_result = '0; fmul_result = '0; fdiv_result = '0;

    // Reset state
    tick(); tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_unit_en", 32'(unit_en), 32'd0);
    check("rst_op_a", op_a, 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_errs", {29'd0, err_illegal, err_timeout, err_spurious}, 32'd0);
    rstn = 1'b1;

    // fsub: enable pulse at T+1, done 5 cycles after enable
    send(3'd1, 32'h4040_0000, 32'h3F80_0000, 6'd5);
    tick(); req_valid = 1'b0;
    check("fsub_en_t1", 32'(unit_en), 32'b0010);
    check("fsub_op_a", op_a, 32'h4040_0000);
    check("fsub_op_b", op_b, 32'h3F80_0000);
    check("fsub_ready_busy", 32'(req_ready), 32'd0);
    tick();
    check("fsub_en_t2", 32'(unit_en), 32'b0000);
    repeat (3) tick();
    check("fsub_no_wb_early", 32'(wb_valid), 32'd0);
    tick(); unit_done = 4'b0010; fsub_result = 32'h4000_0000;
    tick(); unit_done = 4'b0000;
    check("fsub_wb_valid", 32'(wb_valid), 32'd1);
    check("fsub_wb_data", wb_data, 32'h4000_0000);
    check("fsub_wb_rd", 32'(wb_rd), 32'd5);
    tick();
    check("fsub_back_idle", 32'(req_ready), 32'd1);

    // Local ops: fneg, fabs, fmov all write back at T+1 with no unit enable
    send(3'd4, 32'h3F80_0000, 32'h0, 6'd9);
    tick(); req_valid = 1'b0;
    check("fneg_wb_valid", 32'(wb_valid), 32'd1);
    check("fneg_wb_data", wb_data, 32'hBF80_0000);
    check("fneg_wb_rd", 32'(wb_rd), 32'd9);
    check("fneg_unit_en", 32'(unit_en), 32'd0);
    tick();
    send(3'd5, 32'hBF80_0000, 32'h0, 6'd10);
    tick(); req_valid = 1'b0;
    check("fabs_wb_data", wb_data, 32'h3F80_0000);
    tick();
    send(3'd6, 32'h1234_5678, 32'h0, 6'd11);
    tick(); req_valid = 1'b0;
    check("fmov_wb_data", wb_data, 32'h1234_5678);
    check("fmov_wb_rd", 32'(wb_rd), 32'd11);
    tick();

    // fmul with the unit busy for 3 cycles after acceptance
    unit_busy = 4'b0100;
    send(3'd2, 32'h4000_0000, 32'h4040_0000, 6'd3);
    tick(); req_valid = 1'b0;
    check("fmul_busy_en1", 32'(unit_en), 32'd0);
    tick();
    check("fmul_busy_en2", 32'(unit_en), 32'd0);
    tick();
    check("fmul_busy_en3", 32'(unit_en), 32'd0);
    check("fmul_busy_op_a", op_a, 32'h4000_0000);
    tick(); unit_busy = 4'b0000; #1;
    check("fmul_en_free", 32'(unit_en), 32'b0100);
    tick();
    check("fmul_en_once", 32'(unit_en), 32'd0);
    check("fmul_op_b_wait", op_b, 32'h4040_0000);
    unit_done = 4'b0100; fmul_result = 32'h40C0_0000;
    tick(); unit_done = 4'b0000;
    check("fmul_wb_data", wb_data, 32'h40C0_0000);
    check("fmul_wb_rd", 32'(wb_rd), 32'd3);
    check("fmul_op_a_end", op_a, 32'h4000_0000);
    tick();

    // fdiv timeout, then writeback stalled 4 cycles
    send(3'd3, 32'h3F80_0000, 32'h0, 6'd7);
    tick(); req_valid = 1'b0;
    check("fdiv_en", 32'(unit_en), 32'b1000);
    tick();
    repeat (TO - 1) tick();
    check("fdiv_no_to_early", 32'(err_timeout), 32'd0);
    check("fdiv_wait_last", 32'(wb_valid), 32'd0);
    tick();
    check("fdiv_timeout", 32'(err_timeout), 32'd1);
    check("fdiv_to_wb_valid", 32'(wb_valid), 32'd1);
    check("fdiv_to_wb_data", wb_data, 32'h7FC0_0000);
    check("fdiv_to_wb_rd", 32'(wb_rd), 32'd7);
    wb_ready = 1'b0;
    send(3'd4, 32'h1111_1111, 32'h0, 6'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_wb_valid", 32'(wb_valid), 32'd1);
      check("stall_wb_data", wb_data, 32'h7FC0_0000);
      check("stall_wb_rd", 32'(wb_rd), 32'd7);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_to_pulse", 32'(err_timeout), 32'd0);
    end
    wb_ready = 1'b1; req_valid = 1'b0;
    tick();
    check("stall_release", 32'(wb_valid), 32'd0);

    // fdiv with done on the final allowed cycle: real result wins
    send(3'd3, 32'h3F80_0000, 32'h4000_0000, 6'd8);
    tick(); req_valid = 1'b0;
    tick();
    repeat (TO - 1) tick();
    unit_done = 4'b1000; fdiv_result = 32'h3F00_0000;
    tick(); unit_done = 4'b0000;
    check("fdiv_last_wb_data", wb_data, 32'h3F00_0000);
    check("fdiv_last_no_to", 32'(err_timeout), 32'd0);
    check("fdiv_last_wb_rd", 32'(wb_rd), 32'd8);
    tick();

    // Illegal op
    send(3'd7, 32'hFFFF_FFFF, 32'h0, 6'd12);
    tick(); req_valid = 1'b0;
    check("ill_pulse", 32'(err_illegal), 32'd1);
    check("ill_ready", 32'(req_ready), 32'd1);
    check("ill_no_wb", 32'(wb_valid), 32'd0);
    check("ill_unit_en", 32'(unit_en), 32'd0);
    tick();
    check("ill_pulse_end", 32'(err_illegal), 32'd0);

    // Spurious done from an unselected unit during fadd
    send(3'd0, 32'h4000_0000, 32'h4040_0000, 6'd2);
    tick(); req_valid = 1'b0;
    check("fadd_en", 32'(unit_en), 32'b0001);
    tick(); unit_done = 4'b0100;
    tick(); unit_done = 4'b0001; fadd_result = 32'h40A0_0000;
    check("spur_pulse", 32'(err_spurious), 32'd1);
    check("spur_no_wb", 32'(wb_valid), 32'd0);
    tick(); unit_done = 4'b0000;
    check("spur_pulse_end", 32'(err_spurious), 32'd0);
    check("spur_wb_data", wb_data, 32'h40A0_0000);
    check("spur_wb_rd", 32'(wb_rd), 32'd2);
    tick();

    // Reset during WAIT, then a late done must be ignored
    send(3'd1, 32'hAAAA_5555, 32'h5555_AAAA, 6'd4);
    tick(); req_valid = 1'b0;
    tick(); tick();
    rstn = 1'b0;
    tick();
    check("mid_rst_op_a", op_a, 32'h0);
    check("mid_rst_op_b", op_b, 32'h0);
    check("mid_rst_wb", {25'd0, wb_valid, wb_rd}, 32'd0);
    check("mid_rst_wb_data", wb_data, 32'h0);
    check("mid_rst_unit_en", 32'(unit_en), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    rstn = 1'b1; unit_done = 4'b0010; fsub_result = 32'hDEAD_BEEF;
    tick(); unit_done = 4'b0000;
    check("late_done_no_wb", 32'(wb_valid), 32'd0);
    check("late_done_no_err", {29'd0, err_illegal, err_timeout, err_spurious}, 32'd0);
    repeat (TO + 2) tick();
    check("late_done_idle_wb", 32'(wb_valid), 32'd0);
    check("late_done_idle_to", 32'(err_timeout), 32'd0);
    check("late_done_wb_data", wb_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_issue.md
FPU_ISSUE -- requirements
Module: fpu_issue

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, SHALL set the maximum cycles to wait for unit_done after unit_en (range 2..255).
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clk  in  1  clock; all state updates on rising edge
  rstn  in  1  reset, synchronous, active-low
  req_valid  in  1  FP request present
  req_ready  out  1  block can accept a request
  req_op  in  3  0 fadd, 1 fsub, 2 fmul, 3 fdiv, 4 fneg, 5 fabs, 6 fmov, 7 illegal
  req_a / req_b  in  32  IEEE-754 single operands
  req_rd  in  6  destination FP register
  op_a / op_b  out  32  operand bus shared by all four unit wrappers
  unit_en  out  4  one-hot start pulse; bit0 fadd, bit1 fsub, bit2 fmul, bit3 fdiv
  unit_busy  in  4  per-unit busy
  unit_done  in  4  per-unit one-cycle completion pulse
  fadd_result / fsub_result / fmul_result / fdiv_result  in  32 each  unit results, valid when matching done=1
  wb_valid  out  1  writeback present
  wb_ready  in  1  writeback sink accepts
  wb_rd  out  6  destination register
  wb_data  out  32  result
  err_illegal / err_timeout / err_spurious  out  1 each  one-cycle error pulses

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT, WB; req_ready SHALL equal (state==IDLE).
REQ-004 Request accepted in cycle T when req_valid && req_ready: op, rd latched; op_a<=req_a, op_b<=req_b.
REQ-005 Accepted op 0-3: next state ISSUE; sel = one-hot of op.
REQ-006 Accepted op 4/5/6: wb_data <= req_a^0x80000000 / req_a&0x7FFFFFFF / req_a; wb_rd <= req_rd; next state WB (wb_valid=1 at T+1); unit_en never asserted.
REQ-007 Accepted op 7: err_illegal=1 in T+1 only; state stays IDLE; nothing latched to wb; no unit_en.
REQ-008 ISSUE: unit_en = sel when unit_busy&sel == 0, else 0; the cycle unit_en is nonzero, next state WAIT; busy high holds ISSUE indefinitely (no timeout in ISSUE).
REQ-009 unit_en SHALL be high exactly one cycle per request and at most one bit at a time.
REQ-010 op_a/op_b SHALL remain stable from acceptance until the exit of WAIT.
REQ-011 WAIT: 8-bit counter cleared on entry, incremented each cycle; unit_done&sel=1 -> wb_data <= selected result, wb_rd <= rd, next state WB.
REQ-012 WAIT: counter reaching TIMEOUT_CYCLES-1 without selected done -> err_timeout pulse, wb_data <= 0x7FC00000, next state WB; selected done in the same cycle wins (no error, real result).
REQ-013 unit_done from any unselected unit in WAIT SHALL pulse err_spurious and be otherwise ignored; unit_done in IDLE/ISSUE/WB SHALL be ignored silently.
REQ-014 WB: wb_valid=1, wb_rd/wb_data held stable; on wb_valid && wb_ready -> IDLE; next request accepted no earlier than the following cycle.
REQ-015 Minimum latency: unit op, busy low, done at cycle D -> wb_valid at D+1; local op -> wb_valid at T+1.

Reset
REQ-016 rstn=0 at an edge SHALL force IDLE and zero every output register (op_a, op_b, unit_en, wb_valid, wb_rd, wb_data, all err_*), counter=0; holds in any state including mid-WAIT.
REQ-017 A unit_done arriving after reset mid-operation SHALL produce no writeback and no error.

Verification
REQ-018 fsub a=0x40400000 b=0x3F800000, unit_done[1] 5 cycles after en with fsub_result=0x40000000 -> unit_en=0010 for 1 cycle at T+1, wb_valid with wb_data=0x40000000, wb_rd=req_rd.
REQ-019 fneg a=0x3F800000 -> wb_valid at T+1, wb_data=0xBF800000, unit_en stays 0000.
REQ-020 fmul with unit_busy[2]=1 for 3 cycles -> unit_en=0100 asserted only in first cycle busy low, op_a/op_b unchanged throughout.
REQ-021 fdiv, no done -> err_timeout pulse after TIMEOUT_CYCLES, wb_data=0x7FC00000; separate run: done on final cycle -> real result, no error.
REQ-022 wb_ready low 4 cycles -> wb_valid/wb_data/wb_rd held, req_ready=0; op 7 request -> err_illegal 1 cycle, req_ready stays 1.
REQ-023 rstn low during WAIT then late unit_done -> all outputs 0, IDLE, no wb_valid; unselected done during WAIT -> err_spurious 1 cycle, request still completes.
